// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Free-running iterative unsigned restoring divider. Each computation loads the
// operands, resolves one quotient bit per clock, then publishes the quotient
// and remainder. One computation takes WORD_LENGTH+2 clocks. The outputs hold
// their values between publications.
//
// Parameters
//   WORD_LENGTH  operand / result width in bits (>= 2)
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   dividend   in   [WORD_LENGTH-1:0] unsigned numerator, sampled in LOAD
//   divisor    in   [WORD_LENGTH-1:0] unsigned denominator, sampled in LOAD
//   result     out  [WORD_LENGTH-1:0] registered quotient
//   remainder  out  [WORD_LENGTH-1:0] registered remainder
//
// A divisor of 0 is not trapped. Every trial subtraction then succeeds, so the
// result is all ones and the remainder equals the dividend.
// -----------------------------------------------------------------------------
module divider #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] remainder
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DIVIDE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   dvd;        // dividend, shifted out MSB-first and refilled with quotient bits
    logic [W-1:0]   dsr;        // divisor captured at LOAD
    logic [W-1:0]   prem;       // partial remainder

    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           qbit;
    logic [W-1:0]   prem_nxt;

    // One restoring step. The trial subtraction is done on W+1 bits.
    // If shifted[W] is set, shifted is at least 2^W, so it exceeds any divisor.
    // Otherwise a negative difference wraps into the range where bit W is set.
    // That makes "shifted >= divisor" equal to shifted[W] | ~diff[W].
    // A successful difference is always below the divisor, because prem is
    // always below the divisor (or prem only gathers dividend bits when the
    // divisor is 0). So the low W bits of the difference are exact.
    function automatic logic [W:0] restore_step(
        input logic [W:0]   sh,
        input logic [W-1:0] d
    );
        logic [W:0] df;
        logic       ge;
        df = sh - {1'b0, d};
        ge = sh[W] | ~df[W];
        if (ge) begin
            return {1'b1, df[W-1:0]};
        end
        return {1'b0, sh[W-1:0]};
    endfunction

    always_comb begin
        shifted              = {prem, dvd[W-1]};
        diff                 = restore_step(shifted, dsr);
        qbit                 = diff[W];
        prem_nxt             = diff[W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The counter is tested before it is decremented, so
    // the DIVIDE cycle that sees cnt == 1 is the last of WORD_LENGTH.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = DIVIDE;
            DIVIDE:  state_nxt = (cnt == CW'(1)) ? UPDATE : DIVIDE;
            UPDATE:  state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            result    <= '0;
            remainder <= '0;
        end else begin
            case (state)
                LOAD: begin
                    dvd  <= dividend;
                    dsr  <= divisor;
                    prem <= '0;
                    cnt  <= CW'(W);
                end
                DIVIDE: begin
                    dvd  <= {dvd[W-2:0], qbit};
                    prem <= prem_nxt;
                    cnt  <= cnt - CW'(1);
                end
                UPDATE: begin
                    result    <= dvd;
                    remainder <= prem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Bench for divider (WORD_LENGTH = 16).
// A reference model tracks the divider at the level of whole computations.
// It counts clocks since reset and captures the operands at the start of each
// period. At the end of each period it publishes a/b and a%b (all ones and a
// when b = 0). A compare process checks the DUT outputs against the model on
// every falling edge. Directed cases also pin literal results at known times.
// -----------------------------------------------------------------------------
module tb_divider;

    localparam int W = 16;
    localparam int P = W + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] result;
    logic [W-1:0] remainder;

    divider #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_ok(input string name, input bit ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: result=%0d remainder=%0d does not satisfy the identity at %0t",
                     name, result, remainder, $time);
        end
    endtask

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
        return a / b;
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return a;
        return a % b;
    endfunction

    // Reference model
    int           k = 0;
    logic [W-1:0] ca = '0;
    logic [W-1:0] cb = '0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_rem = '0;
    bit           upd = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            k     <= 0;
            m_res <= '0;
            m_rem <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= ((k % P) == P - 1);
            if ((k % P) == 0) begin
                ca <= dividend;
                cb <= divisor;
            end
            if ((k % P) == P - 1) begin
                m_res <= model_q(ca, cb);
                m_rem <= model_r(ca, cb);
            end
            k <= k + 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("model_result", result, m_res);
        check("model_remainder", remainder, m_rem);
        if (upd && cb != '0) begin
            check_ok("identity",
                     (longint'(result) * longint'(cb) + longint'(remainder) == longint'(ca))
                     && (remainder < cb));
        end
    end

    // Called on a falling edge. It pulses reset for one rising edge with the
    // operands applied. The next rising edge is then the LOAD.
    task automatic restart(input logic [W-1:0] a, input logic [W-1:0] b);
        reset    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0};
        vecs[1] = '{16'd5,    16'd9,    16'd0,    16'd5};
        vecs[2] = '{16'd7,    16'd0,    16'hFFFF, 16'd7};
        vecs[3] = '{16'd100,  16'd7,    16'd14,   16'd2};
        vecs[4] = '{16'd0,    16'd5,    16'd0,    16'd0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_result", result, 16'd0);
        check("reset_remainder", remainder, 16'd0);

        // 246/89: not visible after 17 edges, visible after 18, repeats
        restart(16'd246, 16'd89);
        repeat (17) @(negedge clk);
        check("early_result", result, 16'd0);
        @(negedge clk);
        check("246_89_result", result, 16'd2);
        check("246_89_remainder", remainder, 16'd68);
        repeat (P) @(negedge clk);
        check("246_89_repeat_result", result, 16'd2);
        check("246_89_repeat_remainder", remainder, 16'd68);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            restart(vecs[i].a, vecs[i].b);
            repeat (P) @(negedge clk);
            check("vec_result", result, vecs[i].q);
            check("vec_remainder", remainder, vecs[i].r);
        end

        // Operands change in mid-DIVIDE and take effect only at the next LOAD
        restart(16'd246, 16'd89);
        repeat (5) @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        repeat (13) @(negedge clk);
        check("midchange_cur_result", result, 16'd2);
        check("midchange_cur_remainder", remainder, 16'd68);
        repeat (P) @(negedge clk);
        check("midchange_next_result", result, 16'd14);
        check("midchange_next_remainder", remainder, 16'd2);

        // One-cycle reset pulse in mid-DIVIDE
        restart(16'd246, 16'd89);
        repeat (P) @(negedge clk);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_result", result, 16'd0);
        check("abort_remainder", remainder, 16'd0);
        reset = 1'b0;
        repeat (17) @(negedge clk);
        check("abort_early_result", result, 16'd0);
        @(negedge clk);
        check("abort_fresh_result", result, 16'd2);
        check("abort_fresh_remainder", remainder, 16'd68);

        // Reset held high with live operands
        reset    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd3;
        repeat (30) @(negedge clk);
        check("held_reset_result", result, 16'd0);
        check("held_reset_remainder", remainder, 16'd0);

        // Random sweep. Operands change every cycle; the model tracks the captures.
        reset = 1'b0;
        for (int c = 0; c < 40 * P; c++) begin
            case ($urandom_range(0, 3))
                0: begin
                    dividend = W'($urandom_range(0, 65535));
                    divisor  = '0;
                end
                1: begin
                    dividend = W'($urandom_range(0, 1000));
                    divisor  = W'($urandom_range(1001, 65535));
                end
                2: begin
                    dividend = W'($urandom_range(0, 65535));
                    divisor  = W'($urandom_range(1, 15));
                end
                default: begin
                    dividend = W'($urandom_range(0, 65535));
                    divisor  = W'($urandom_range(0, 65535));
                end
            endcase
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WORD_LENGTH, default 16, operand/result width in bits (>=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 dividend  input  WORD_LENGTH  unsigned numerator.
REQ-005 divisor  input  WORD_LENGTH  unsigned denominator.
REQ-006 result  output  WORD_LENGTH  registered unsigned quotient.
REQ-007 remainder  output  WORD_LENGTH  registered unsigned remainder.
REQ-008 No other ports shall exist; no start/done handshake.

Function
REQ-009 The block SHALL be a free-running, iterative, unsigned restoring shift-subtract divider with one quotient bit per clock.
REQ-010 FSM states SHALL be LOAD, DIVIDE and UPDATE; the transitions are LOAD->DIVIDE, DIVIDE->DIVIDE while the iteration counter is nonzero, last DIVIDE->UPDATE, and UPDATE->LOAD.
REQ-011 LOAD (1 cycle) SHALL capture dividend and divisor into internal registers, clear the partial remainder and set the iteration counter to WORD_LENGTH.
REQ-012 Each DIVIDE cycle SHALL shift {partial remainder, dividend register} left by 1 bit.
REQ-013 In each DIVIDE cycle, if the shifted partial remainder is >= the captured divisor, the block SHALL subtract the divisor and set the new quotient LSB to 1; otherwise the quotient LSB SHALL be 0.
REQ-014 Each DIVIDE cycle SHALL decrement the counter; there SHALL be exactly WORD_LENGTH DIVIDE cycles.
REQ-015 The partial-remainder compare/subtract SHALL use WORD_LENGTH+1 bits so that no carry is lost.
REQ-016 UPDATE (1 cycle) SHALL write the quotient to result and the final partial remainder to remainder.
REQ-017 result and remainder SHALL hold their values at all other times.
REQ-018 Computation period SHALL be WORD_LENGTH+2 cycles (18 for the default).
REQ-019 Outputs for operands captured at LOAD edge N SHALL be visible after edge N+WORD_LENGTH+1.
REQ-020 Input changes after the LOAD edge SHALL NOT affect the computation in progress; they take effect at the next LOAD.
REQ-021 Divisor = 0 SHALL yield result = all ones and remainder = dividend, which is the natural restoring outcome with no special trap.
REQ-022 The outputs SHALL satisfy dividend = result*divisor + remainder with remainder < divisor whenever divisor != 0.
REQ-023 No combinational path SHALL exist from the inputs to the outputs.

Reset
REQ-024 While reset=1 at a rising edge: result=0, remainder=0, FSM=LOAD, counter=0, internal operand, quotient and partial-remainder registers cleared.
REQ-025 Reset asserted mid-DIVIDE SHALL abort the computation without updating the outputs to partial values; the outputs go to 0.
REQ-026 The first LOAD SHALL occur on the first rising edge at which reset=0.
REQ-027 Reset held high indefinitely SHALL keep result=0 and remainder=0.

Verification
REQ-028 W=16, dividend=246, divisor=89, reset released -> after 18 edges result=2, remainder=68, repeating every 18 cycles.
REQ-029 dividend=0xFFFF, divisor=1 -> result=0xFFFF, remainder=0; dividend=5, divisor=9 -> result=0, remainder=5.
REQ-030 dividend=7, divisor=0 -> result=0xFFFF, remainder=7.
REQ-031 Operands changed 246/89->100/7 mid-DIVIDE -> current UPDATE gives 2/68, the next period gives 14/2.
REQ-032 Reset pulsed for 1 cycle mid-DIVIDE -> outputs 0 the following cycle; a fresh 18-cycle computation then produces the correct values.
REQ-033 Random-operand sweep (including divisor=0 and divisor>dividend) -> REQ-021/REQ-022 checked at every UPDATE.
